// File: rtl/alu_vec_if.sv
// Request/response handshake bundle between a stimulus source and alu_vec_driver.
// The master side issues stimulus vectors and consumes results; the slave side is the driver.
interface alu_vec_if #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [IN_W-1:0]  req_vec;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OUT_W-1:0] rsp_vec;

  modport master (
    output req_valid, req_vec, rsp_ready,
    input  req_ready, rsp_valid, rsp_vec
  );

  modport slave (
    input  req_valid, req_vec, rsp_ready,
    output req_ready, rsp_valid, rsp_vec
  );
endinterface

// File: rtl/alu_vec_driver.sv
// Drives stimulus onto a combinational ALU cone, samples its result after a settle delay,
// and can sweep every input vector while folding the results into a MISR signature.
module alu_vec_driver #(
  parameter int unsigned      IN_W     = 10,
  parameter int unsigned      OUT_W    = 6,
  parameter int unsigned      SETTLE   = 1,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_vec_if.slave         bus,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [SIG_W-1:0] signature,
  output logic [IN_W-1:0]  alu_in,
  input  logic [OUT_W-1:0] alu_out
);

  if (SETTLE == 0 || SETTLE > 15) begin : g_bad_settle
    $error("alu_vec_driver: SETTLE must be in 1..15");
  end
  if (OUT_W > SIG_W) begin : g_bad_out_w
    $error("alu_vec_driver: OUT_W must not exceed SIG_W");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;
  localparam logic [1:0] StSweep = 2'd3;

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]  alu_in_q, alu_in_d;
  logic [OUT_W-1:0] rsp_vec_q, rsp_vec_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] sig_fold;
  logic             req_ready;

  // sweep_start pre-empts a same-cycle request, so ready drops combinationally with it.
  assign req_ready = (state_q == StIdle) & ~sweep_start;

  assign sig_fold = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^
                    SIG_W'(alu_out);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_in_d    = alu_in_q;
    rsp_vec_d   = rsp_vec_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sig_d       = sig_q;
    unique case (state_q)
      StIdle: begin
        if (sweep_start) begin
          state_d  = StSweep;
          alu_in_d = '0;
          sig_d    = SIG_SEED;
          cnt_d    = SettleCnt;
          busy_d   = 1'b1;
        end else if (bus.req_valid && req_ready) begin
          state_d  = StWait;
          alu_in_d = bus.req_vec;
          cnt_d    = SettleCnt;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_vec_d   = alu_out;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StSweep: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          sig_d = sig_fold;
          if (alu_in_q != '1) begin
            alu_in_d = alu_in_q + IN_W'(1);
            cnt_d    = SettleCnt;
          end else begin
            // Last vector folded: no wrap back to zero, alu_in stays at all-ones.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_in_q    <= '0;
      rsp_vec_q   <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sig_q       <= SIG_SEED;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_in_q    <= alu_in_d;
      rsp_vec_q   <= rsp_vec_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sig_q       <= sig_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_vec   = rsp_vec_q;
  assign sweep_busy    = busy_q;
  assign sweep_done    = done_q;
  assign signature     = sig_q;
  assign alu_in        = alu_in_q;

endmodule

// File: tb/tb_alu_vec_driver.sv
// Bench for alu_vec_driver: one instance with SETTLE=1 on a loopback/zero ALU, one with
// SETTLE=3 on a small arithmetic ALU; results are checked against a behavioural model.
module tb_alu_vec_driver;
  localparam int unsigned IN_W  = 10;
  localparam int unsigned OUT_W = 6;
  localparam int unsigned SIG_W = 16;
  localparam int unsigned NVEC  = 1 << IN_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU standing in for the alu2_cl netlist: op in [9:8], operands a/b nibbles.
  function automatic logic [5:0] ref_alu(input logic [9:0] v);
    logic [3:0] a, b;
    logic [7:0] p;
    a = v[7:4];
    b = v[3:0];
    p = 8'(a) * 8'(b);
    case (v[9:8])
      2'd0:    return 6'(a) + 6'(b);
      2'd1:    return 6'(a) - 6'(b);
      2'd2:    return {a ^ b, 2'b01};
      default: return p[5:0];
    endcase
  endfunction

  // One MISR step: multiply by x over GF(2) modulo the polynomial, then add the input word.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    logic [16:0] sh;
    sh = {s, 1'b0};
    if (sh[16]) sh = sh ^ 17'h11021;
    return sh[15:0] ^ d;
  endfunction

  // DUT with SETTLE=1
  alu_vec_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();
  logic             sweep_start1, sweep_busy1, sweep_done1;
  logic [SIG_W-1:0] sig1;
  logic [IN_W-1:0]  alu_in1;
  logic [OUT_W-1:0] alu_out1;
  logic             alu_zero;
  assign alu_out1 = alu_zero ? '0 : alu_in1[5:0];

  alu_vec_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .sweep_start(sweep_start1),
    .sweep_busy(sweep_busy1), .sweep_done(sweep_done1), .signature(sig1),
    .alu_in(alu_in1), .alu_out(alu_out1)
  );

  // DUT with SETTLE=3
  alu_vec_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus3 ();
  logic             sweep_start3, sweep_busy3, sweep_done3;
  logic [SIG_W-1:0] sig3;
  logic [IN_W-1:0]  alu_in3;
  logic [OUT_W-1:0] alu_out3;
  assign alu_out3 = ref_alu(alu_in3);

  alu_vec_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .sweep_start(sweep_start3),
    .sweep_busy(sweep_busy3), .sweep_done(sweep_done3), .signature(sig3),
    .alu_in(alu_in3), .alu_out(alu_out3)
  );

  task automatic idle_inputs();
    bus1.req_valid = 1'b0; bus1.req_vec = '0; bus1.rsp_ready = 1'b0; sweep_start1 = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_vec = '0; bus3.rsp_ready = 1'b0; sweep_start3 = 1'b0;
  endtask

  task automatic test_reset();
    bus1.req_valid = 1'b1; bus1.req_vec = 10'h3C7; sweep_start3 = 1'b1;
    @(negedge clk);
    bus1.req_valid = 1'b0; sweep_start3 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus1.rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_resp: rsp_valid=%b want 1", bus1.rsp_valid);
    end
    n_checks++;
    if (sweep_busy3 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_sweep: sweep_busy=%b want 1", sweep_busy3);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus1.rsp_valid, alu_in1, sig1} !== {1'b0, 10'h0, 16'hFFFF}) begin
      n_fail++; $display("FAIL reset_resp: rsp_valid=%b alu_in=%h sig=%h want 0/000/ffff",
                         bus1.rsp_valid, alu_in1, sig1);
    end
    n_checks++;
    if ({sweep_busy3, sweep_done3, alu_in3, sig3} !== {2'b00, 10'h0, 16'hFFFF}) begin
      n_fail++; $display("FAIL reset_sweep: busy=%b done=%b alu_in=%h sig=%h want 0/0/000/ffff",
                         sweep_busy3, sweep_done3, alu_in3, sig3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus1.req_ready, bus3.req_ready, bus1.rsp_vec} !== {2'b11, 6'h0}) begin
      n_fail++; $display("FAIL reset_release: req_ready1=%b req_ready3=%b rsp_vec=%h want 1/1/00",
                         bus1.req_ready, bus3.req_ready, bus1.rsp_vec);
    end
    @(negedge clk);
  endtask

  task automatic test_loopback();
    bus1.req_valid = 1'b1; bus1.req_vec = 10'h2A5;
    #1;
    n_checks++;
    if (bus1.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL loop_ready: req_ready=%b want 1", bus1.req_ready);
    end
    @(negedge clk);
    bus1.req_valid = 1'b0;
    n_checks++;
    if ({alu_in1, bus1.rsp_valid, bus1.req_ready} !== {10'h2A5, 2'b00}) begin
      n_fail++; $display("FAIL loop_drive: alu_in=%h rsp_valid=%b req_ready=%b want 2a5/0/0",
                         alu_in1, bus1.rsp_valid, bus1.req_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({bus1.rsp_valid, bus1.rsp_vec} !== {1'b1, 6'h25}) begin
      n_fail++; $display("FAIL loop_rsp: rsp_valid=%b rsp_vec=%h want 1/25",
                         bus1.rsp_valid, bus1.rsp_vec);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    n_checks++;
    if ({bus1.rsp_valid, bus1.req_ready, alu_in1} !== {2'b01, 10'h2A5}) begin
      n_fail++; $display("FAIL loop_release: rsp_valid=%b req_ready=%b alu_in=%h want 0/1/2a5",
                         bus1.rsp_valid, bus1.req_ready, alu_in1);
    end
  endtask

  task automatic test_backpressure();
    bus1.req_valid = 1'b1; bus1.req_vec = 10'h001;
    @(negedge clk);
    bus1.req_vec = 10'h03C;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus1.rsp_valid, bus1.rsp_vec, bus1.req_ready, alu_in1} !== {1'b1, 6'h01, 1'b0, 10'h001})
      begin
        n_fail++; $display("FAIL bp_hold[%0d]: rsp_valid=%b rsp_vec=%h req_ready=%b alu_in=%h",
                           i, bus1.rsp_valid, bus1.rsp_vec, bus1.req_ready, alu_in1);
      end
      @(negedge clk);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    n_checks++;
    if ({bus1.rsp_valid, bus1.req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_idle: rsp_valid=%b req_ready=%b want 0/1",
                         bus1.rsp_valid, bus1.req_ready);
    end
    @(negedge clk);
    bus1.req_valid = 1'b0;
    n_checks++;
    if ({alu_in1, bus1.req_ready} !== {10'h03C, 1'b0}) begin
      n_fail++; $display("FAIL bp_second: alu_in=%h req_ready=%b want 03c/0",
                         alu_in1, bus1.req_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({bus1.rsp_valid, bus1.rsp_vec} !== {1'b1, 6'h3C}) begin
      n_fail++; $display("FAIL bp_second_rsp: rsp_valid=%b rsp_vec=%h want 1/3c",
                         bus1.rsp_valid, bus1.rsp_vec);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
  endtask

  task automatic test_sweep_zero();
    logic [15:0] exp_sig;
    int          done_at;
    exp_sig = 16'hFFFF;
    for (int i = 0; i < int'(NVEC); i++) exp_sig = misr_step(exp_sig, 16'h0);
    alu_zero = 1'b1;
    sweep_start1 = 1'b1;
    done_at = -1;
    for (int k = 0; k <= 1100 && done_at < 0; k++) begin
      @(negedge clk);
      sweep_start1 = 1'b0;
      if (sweep_done1) done_at = k;
    end
    n_checks++;
    if (done_at != int'(NVEC)) begin
      n_fail++; $display("FAIL sweep0_cycles: done after %0d cycles want %0d", done_at, NVEC);
    end
    n_checks++;
    if ({sweep_busy1, sig1, alu_in1} !== {1'b0, exp_sig, 10'h3FF}) begin
      n_fail++; $display("FAIL sweep0_sig: busy=%b sig=%h alu_in=%h want 0/%h/3ff",
                         sweep_busy1, sig1, alu_in1, exp_sig);
    end
    @(negedge clk);
    n_checks++;
    if ({sweep_done1, sig1} !== {1'b0, exp_sig}) begin
      n_fail++; $display("FAIL sweep0_pulse: done=%b sig=%h want 0/%h", sweep_done1, sig1, exp_sig);
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_start_priority();
    logic [15:0] exp_sig;
    int          done_at;
    exp_sig = 16'hFFFF;
    for (int v = 0; v < int'(NVEC); v++) exp_sig = misr_step(exp_sig, 16'(v % 64));
    sweep_start1 = 1'b1; bus1.req_valid = 1'b1; bus1.req_vec = 10'h155;
    #1;
    n_checks++;
    if (bus1.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL prio_ready: req_ready=%b want 0", bus1.req_ready);
    end
    @(negedge clk);
    sweep_start1 = 1'b0; bus1.req_valid = 1'b0;
    n_checks++;
    if ({sweep_busy1, alu_in1, bus1.rsp_valid} !== {1'b1, 10'h000, 1'b0}) begin
      n_fail++; $display("FAIL prio_sweep: busy=%b alu_in=%h rsp_valid=%b want 1/000/0",
                         sweep_busy1, alu_in1, bus1.rsp_valid);
    end
    done_at = -1;
    for (int k = 1; k <= 1100 && done_at < 0; k++) begin
      @(negedge clk);
      if (sweep_done1) done_at = k;
    end
    n_checks++;
    if (done_at != int'(NVEC) || sig1 !== exp_sig) begin
      n_fail++; $display("FAIL prio_loop_sig: done after %0d sig=%h want %0d/%h",
                         done_at, sig1, NVEC, exp_sig);
    end
    n_checks++;
    if (bus1.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL prio_no_rsp: rsp_valid=%b want 0", bus1.rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep_alu();
    logic [15:0] exp_sig;
    int          done_at;
    exp_sig = 16'hFFFF;
    for (int v = 0; v < int'(NVEC); v++) exp_sig = misr_step(exp_sig, 16'(ref_alu(10'(v))));
    for (int run = 0; run < 2; run++) begin
      sweep_start3 = 1'b1;
      done_at = -1;
      for (int k = 0; k <= 3200 && done_at < 0; k++) begin
        @(negedge clk);
        sweep_start3 = 1'b0;
        if (sweep_done3) done_at = k;
      end
      n_checks++;
      if (done_at != int'(3 * NVEC)) begin
        n_fail++; $display("FAIL alu_sweep_cycles[%0d]: done after %0d want %0d",
                           run, done_at, 3 * NVEC);
      end
      n_checks++;
      if (sig3 !== exp_sig) begin
        n_fail++; $display("FAIL alu_sweep_sig[%0d]: sig=%h want %h", run, sig3, exp_sig);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sweep_busy3, sig3} !== {1'b0, exp_sig}) begin
        n_fail++; $display("FAIL alu_sweep_hold[%0d]: busy=%b sig=%h want 0/%h",
                           run, sweep_busy3, sig3, exp_sig);
      end
    end
  endtask

  task automatic test_random_requests();
    logic [9:0] v;
    int         stall;
    for (int t = 0; t < 12; t++) begin
      v = 10'($urandom);
      stall = int'($urandom_range(0, 3));
      bus3.req_valid = 1'b1; bus3.req_vec = v;
      @(negedge clk);
      bus3.req_valid = 1'b0; bus3.req_vec = 10'($urandom);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if ({bus3.rsp_valid, alu_in3} !== {1'b0, v}) begin
          n_fail++; $display("FAIL rnd_wait[%0d.%0d]: rsp_valid=%b alu_in=%h want 0/%h",
                             t, c, bus3.rsp_valid, alu_in3, v);
        end
        @(negedge clk);
      end
      for (int c = 0; c <= stall; c++) begin
        n_checks++;
        if ({bus3.rsp_valid, bus3.rsp_vec, bus3.req_ready} !== {1'b1, ref_alu(v), 1'b0}) begin
          n_fail++; $display("FAIL rnd_rsp[%0d.%0d]: rsp_valid=%b rsp_vec=%h req_ready=%b want 1/%h/0",
                             t, c, bus3.rsp_valid, bus3.rsp_vec, bus3.req_ready, ref_alu(v));
        end
        if (c == stall) bus3.rsp_ready = 1'b1;
        @(negedge clk);
      end
      bus3.rsp_ready = 1'b0;
      n_checks++;
      if ({bus3.rsp_valid, bus3.req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL rnd_done[%0d]: rsp_valid=%b req_ready=%b want 0/1",
                           t, bus3.rsp_valid, bus3.req_ready);
      end
    end
  endtask

  initial begin
    alu_zero = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_backpressure();
    test_sweep_zero();
    test_start_priority();
    test_sweep_alu();
    test_random_requests();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
